// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port bypassing register file.
// RF_ZERO_REG_EN (optional macro) hardwires register 0 to zero in the users of this package.
package rf_pkg;

   localparam int RF_DATA_W_DEF = 16;
   localparam int RF_N_REGS_DEF = 8;
   localparam int RF_NUM_RD_DEF = 2;

   typedef logic [RF_DATA_W_DEF-1:0] rf_word_t;

   // Write port 1 wins both the array collision and the read bypass.
   localparam int unsigned RF_WR_PRIO_HI = 1;
   localparam int unsigned RF_WR_PRIO_LO = 0;

endpackage

// File: rtl/rf_bypass_sel.sv
// One read port: write-to-read bypass priority, out-of-range zeroing and zero-register gating.
// Optional macro RF_ZERO_REG_EN: index 0 reads as zero and ignores any bypass.
module rf_bypass_sel
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W_DEF,
   parameter int N_REGS = RF_N_REGS_DEF,
   parameter int SEL_W  = $clog2(RF_N_REGS_DEF)
) (
   input  logic [SEL_W-1:0]  i_rd_sel,
   input  logic              i_wr0_en,
   input  logic [SEL_W-1:0]  i_wr0_sel,
   input  logic [DATA_W-1:0] i_wr0_data,
   input  logic              i_wr1_en,
   input  logic [SEL_W-1:0]  i_wr1_sel,
   input  logic [DATA_W-1:0] i_wr1_data,
   input  logic [DATA_W-1:0] i_arr_word,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_oor
);

   logic              w_hit  [2];
   logic [DATA_W-1:0] w_data [2];
   logic              w_zero;

   assign o_oor     = ({1'b0, i_rd_sel} >= (SEL_W+1)'(N_REGS));
   assign w_hit[0]  = i_wr0_en && (i_wr0_sel == i_rd_sel);
   assign w_hit[1]  = i_wr1_en && (i_wr1_sel == i_rd_sel);
   assign w_data[0] = i_wr0_data;
   assign w_data[1] = i_wr1_data;

`ifdef RF_ZERO_REG_EN
   assign w_zero = (i_rd_sel == '0);
`else
   assign w_zero = 1'b0;
`endif

   always_comb begin
      o_rd_data = '0;
      if (!o_oor && !w_zero) begin
         if (w_hit[RF_WR_PRIO_HI])      o_rd_data = w_data[RF_WR_PRIO_HI];
         else if (w_hit[RF_WR_PRIO_LO]) o_rd_data = w_data[RF_WR_PRIO_LO];
         else                           o_rd_data = i_arr_word;
      end
   end

endmodule

// File: rtl/rf_bypass_mp.sv
// Multi-read-port register file with two prioritised write ports, same-cycle bypass and sticky err.
// Optional macro RF_ZERO_REG_EN: register 0 hardwired to zero (writes dropped silently, reads 0).
module rf_bypass_mp
   import rf_pkg::*;
#(
   parameter  int DATA_W = RF_DATA_W_DEF,
   parameter  int N_REGS = RF_N_REGS_DEF,
   parameter  int NUM_RD = RF_NUM_RD_DEF,
   localparam int SEL_W  = $clog2(N_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [SEL_W-1:0]         wr0_sel,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [SEL_W-1:0]         wr1_sel,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     err_clr,
   output logic                     err
);

   logic [DATA_W-1:0] r_regs [N_REGS];
   logic              r_err;

   logic              w_wr_en   [2];
   logic [SEL_W-1:0]  w_wr_sel  [2];
   logic [DATA_W-1:0] w_wr_data [2];
   logic              w_wr_oor  [2];
   logic              w_wr_zero [2];
   logic              w_wr_ok   [2];
   logic [NUM_RD-1:0] w_rd_oor;
   logic              w_coll;
   logic              w_err_set;

   assign w_wr_en[0]   = wr0_en;
   assign w_wr_sel[0]  = wr0_sel;
   assign w_wr_data[0] = wr0_data;
   assign w_wr_en[1]   = wr1_en;
   assign w_wr_sel[1]  = wr1_sel;
   assign w_wr_data[1] = wr1_data;

   for (genvar k = 0; k < 2; k++) begin : g_wr
      assign w_wr_oor[k] = w_wr_en[k] && ({1'b0, w_wr_sel[k]} >= (SEL_W+1)'(N_REGS));
`ifdef RF_ZERO_REG_EN
      assign w_wr_zero[k] = (w_wr_sel[k] == '0);
`else
      assign w_wr_zero[k] = 1'b0;
`endif
      assign w_wr_ok[k] = w_wr_en[k] && !w_wr_oor[k] && !w_wr_zero[k];
   end

   // Low-priority port is applied first so the high-priority assignment lands last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < N_REGS; r++) r_regs[r] <= '0;
      end else begin
         for (int r = 0; r < N_REGS; r++) begin
            if (w_wr_ok[RF_WR_PRIO_LO] && (w_wr_sel[RF_WR_PRIO_LO] == SEL_W'(r)))
               r_regs[r] <= w_wr_data[RF_WR_PRIO_LO];
            if (w_wr_ok[RF_WR_PRIO_HI] && (w_wr_sel[RF_WR_PRIO_HI] == SEL_W'(r)))
               r_regs[r] <= w_wr_data[RF_WR_PRIO_HI];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [SEL_W-1:0]  w_sel;
      logic [DATA_W-1:0] w_arr_word;

      assign w_sel = rd_sel[p*SEL_W +: SEL_W];

      // Explicit compare-mux keeps out-of-range selects from indexing past the array.
      always_comb begin
         w_arr_word = '0;
         for (int r = 0; r < N_REGS; r++)
            if (w_sel == SEL_W'(r)) w_arr_word = r_regs[r];
      end

      rf_bypass_sel #(
         .DATA_W (DATA_W),
         .N_REGS (N_REGS),
         .SEL_W  (SEL_W)
      ) u_sel (
         .i_rd_sel   (w_sel),
         .i_wr0_en   (wr0_en),
         .i_wr0_sel  (wr0_sel),
         .i_wr0_data (wr0_data),
         .i_wr1_en   (wr1_en),
         .i_wr1_sel  (wr1_sel),
         .i_wr1_data (wr1_data),
         .i_arr_word (w_arr_word),
         .o_rd_data  (rd_data[p*DATA_W +: DATA_W]),
         .o_oor      (w_rd_oor[p])
      );
   end

   assign w_coll    = wr0_en && wr1_en && (wr0_sel == wr1_sel) && !w_wr_zero[0];
   assign w_err_set = w_coll || w_wr_oor[0] || w_wr_oor[1] || (|w_rd_oor);

   // A new error event in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_err <= 1'b0;
      else      r_err <= w_err_set || (r_err && !err_clr);
   end

   assign err = r_err;

endmodule
